// File: rtl/fanout_branch_checker.sv
// Fanout branch agreement checker: registers all branches each cycle, counts disagreeing
// samples over a WIN_LEN window and presents a report on a valid/ready handshake.
module fanout_branch_checker #(
    parameter int N_BRANCH = 8,
    parameter int WIN_LEN  = 16,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1
) (
    input  logic                iccad_clk,
    input  logic                iccad_rst,
    input  logic                start,
    input  logic [N_BRANCH-1:0] branch_in,
    output logic                busy,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [CNT_W-1:0]    rpt_mismatch_cnt,
    output logic                rpt_has_mismatch,
    output logic [IDX_W-1:0]    rpt_first_idx,
    output logic [N_BRANCH-1:0] rpt_first_mask,
    output logic                rpt_value
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    state_t              r_state;
    logic [N_BRANCH-1:0] r_branch_q;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_valid;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_has;
    logic [IDX_W-1:0]    r_first_idx;
    logic [N_BRANCH-1:0] r_first_mask;
    logic                r_value;

    logic                w_mismatch;
    logic [N_BRANCH-1:0] w_mask;

    // A sample agrees only when every branch carries the same value.
    assign w_mismatch = (|r_branch_q) && !(&r_branch_q);
    assign w_mask     = r_branch_q ^ {N_BRANCH{r_branch_q[0]}};

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            r_state      <= S_IDLE;
            r_branch_q   <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_cnt        <= '0;
            r_has        <= 1'b0;
            r_first_idx  <= '0;
            r_first_mask <= '0;
            r_value      <= 1'b0;
        end else begin
            r_branch_q <= branch_in;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_idx        <= '0;
                        r_cnt        <= '0;
                        r_has        <= 1'b0;
                        r_first_idx  <= '0;
                        r_first_mask <= '0;
                        r_value      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_mismatch) begin
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + CNT_W'(1);
                        // The counter saturates rather than wraps, so zero marks the first mismatch.
                        if (r_cnt == '0) begin
                            r_first_idx  <= r_idx;
                            r_first_mask <= w_mask;
                        end
                        r_has <= 1'b1;
                    end else begin
                        r_value <= r_branch_q[0];
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_REPORT;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign rpt_valid        = r_valid;
    assign rpt_mismatch_cnt = r_cnt;
    assign rpt_has_mismatch = r_has;
    assign rpt_first_idx    = r_first_idx;
    assign rpt_first_mask   = r_first_mask;
    assign rpt_value        = r_value;

endmodule
